// File: rtl/cmp_pkg.sv
// cmp_pkg: shared types and sizing helpers for the time-multiplexed compare
// engine (cmp_slice_sched) and its comparator slice (cmp3_slice).
//   cmp_state_e : scheduler FSM states
//   cmp_res_t   : one-hot {lt, eq, gt} compare outcome, also the cascade carry
//   CMP_EQ      : "equal so far" value that seeds the cascade
//   num_chunks  : ceiling of operand width over slice width
package cmp_pkg;

  localparam int CMP_DATA_W  = 8;
  localparam int CMP_SLICE_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cmp_state_e;

  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
  } cmp_res_t;

  localparam cmp_res_t CMP_EQ = '{lt: 1'b0, eq: 1'b1, gt: 1'b0};

  function automatic int num_chunks(input int data_w, input int slice_w);
    return (data_w + slice_w - 1) / slice_w;
  endfunction

endpackage

// File: rtl/cmp3_slice.sv
// cmp3_slice: combinational SLICE_W-bit magnitude comparator with cascade.
// Chunks are fed least-significant first, so a more significant chunk that
// differs overrides whatever was carried in; equal chunks pass the carry.
// Ports:
//   a, b  : operand chunks
//   cin   : {lt, eq, gt} result of the less significant chunks
//   cout  : {lt, eq, gt} result including this chunk
module cmp3_slice
  import cmp_pkg::*;
#(
  parameter int SLICE_W = CMP_SLICE_W
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  cmp_res_t           cin,
  output cmp_res_t           cout
);

  always_comb begin
    cout = cin;
    if (a < b) begin
      cout = '{lt: 1'b1, eq: 1'b0, gt: 1'b0};
    end else if (a > b) begin
      cout = '{lt: 1'b0, eq: 1'b0, gt: 1'b1};
    end
  end

endmodule

// File: rtl/cmp_slice_sched.sv
// cmp_slice_sched: two-requester magnitude compare engine built around one
// shared SLICE_W-bit comparator slice. A round-robin arbiter accepts one
// operand pair at a time; the FSM then walks the slice over the chunks,
// least significant first, and returns {lt, eq, gt} with the owner id over a
// valid/ready handshake.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   reqN_valid/ready/a/b (N=0,1)  : operand request channels
//   res_valid/ready               : result handshake
//   res_id                        : requester that owns the result
//   res_lt/res_eq/res_gt          : one-hot compare outcome (A vs B)
//   busy                          : high while a compare is in flight or held
// Build option:
//   CMP_SIGNED_EN : treat operands as two's complement (MSB inverted at latch)
module cmp_slice_sched
  import cmp_pkg::*;
#(
  parameter int DATA_W  = CMP_DATA_W,
  parameter int SLICE_W = CMP_SLICE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_id,
  output logic              res_lt,
  output logic              res_eq,
  output logic              res_gt,
  output logic              busy
);

  localparam int NUM_CHUNKS = num_chunks(DATA_W, SLICE_W);
  localparam int PAD_W      = NUM_CHUNKS * SLICE_W;
  localparam int PAD        = PAD_W - DATA_W;
  localparam int CIDX_W     = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CIDX_W-1:0] LAST_IDX = CIDX_W'(NUM_CHUNKS - 1);

  cmp_state_e        state;
  logic              last_grant;
  logic [CIDX_W-1:0] chunk_idx;
  cmp_res_t          carry;

  logic [PAD_W-1:0]  opa_p0;
  logic [PAD_W-1:0]  opb_p0;
  logic              own_p0;

  logic              gnt;
  logic              accept;
  logic [DATA_W-1:0] a_sel;
  logic [DATA_W-1:0] b_sel;
  logic [DATA_W-1:0] a_in;
  logic [DATA_W-1:0] b_in;
  logic [SLICE_W-1:0] a_chunk;
  logic [SLICE_W-1:0] b_chunk;
  cmp_res_t          slice_out;

  // Round-robin: on a tie the requester that did not win last time is granted.
  always_comb begin
    gnt = 1'b0;
    if (req0_valid && req1_valid) begin
      gnt = ~last_grant;
    end else if (req1_valid) begin
      gnt = 1'b1;
    end
  end

  assign req0_ready = (state == IDLE) && !rst && req0_valid && !gnt;
  assign req1_ready = (state == IDLE) && !rst && req1_valid &&  gnt;
  assign accept     = req0_ready || req1_ready;
  assign busy       = (state == RUN) || (state == DONE);

  assign a_sel = gnt ? req1_a : req0_a;
  assign b_sel = gnt ? req1_b : req0_b;

`ifdef CMP_SIGNED_EN
  // Flipping the sign bit maps two's complement order onto unsigned order.
  assign a_in = {~a_sel[DATA_W-1], a_sel[DATA_W-2:0]};
  assign b_in = {~b_sel[DATA_W-1], b_sel[DATA_W-2:0]};
`else
  assign a_in = a_sel;
  assign b_in = b_sel;
`endif

  // Stage p0: operands latched on accept, zero-padded at the LSB end so that
  // every chunk is a full slice wide.
  always_ff @(posedge clk) begin
    if (accept) begin
      opa_p0 <= PAD_W'(a_in) << PAD;
      opb_p0 <= PAD_W'(b_in) << PAD;
      own_p0 <= gnt;
    end
  end

  assign a_chunk = opa_p0[int'(chunk_idx) * SLICE_W +: SLICE_W];
  assign b_chunk = opb_p0[int'(chunk_idx) * SLICE_W +: SLICE_W];

  cmp3_slice #(
    .SLICE_W (SLICE_W)
  ) u_slice (
    .a    (a_chunk),
    .b    (b_chunk),
    .cin  (carry),
    .cout (slice_out)
  );

  // Stage p1: one chunk per RUN cycle, carry registered between passes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      res_valid  <= 1'b0;
      res_id     <= 1'b0;
      res_lt     <= 1'b0;
      res_eq     <= 1'b1;
      res_gt     <= 1'b0;
      last_grant <= 1'b1;
      chunk_idx  <= '0;
      carry      <= CMP_EQ;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            last_grant <= gnt;
            chunk_idx  <= '0;
            carry      <= CMP_EQ;
            state      <= RUN;
          end
        end
        RUN: begin
          carry     <= slice_out;
          chunk_idx <= chunk_idx + CIDX_W'(1);
          if (chunk_idx == LAST_IDX) begin
            res_lt    <= slice_out.lt;
            res_eq    <= slice_out.eq;
            res_gt    <= slice_out.gt;
            res_id    <= own_p0;
            res_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (res_valid && res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_slice_sched.sv
// tb_cmp_slice_sched: directed-vector bench for cmp_slice_sched with
// hand-computed expected results. Honours CMP_SIGNED_EN for the vectors
// whose outcome depends on signedness.
module tb_cmp_slice_sched;

`ifdef CMP_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       req0_valid, req0_ready;
  logic [7:0] req0_a, req0_b;
  logic       req1_valid, req1_ready;
  logic [7:0] req1_a, req1_b;
  logic       res_valid, res_ready, res_id;
  logic       res_lt, res_eq, res_gt;
  logic       busy;

  int n_vec;
  int n_err;

  cmp_slice_sched dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_id     (res_id),
    .res_lt     (res_lt),
    .res_eq     (res_eq),
    .res_gt     (res_gt),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts at posedge+1 of an IDLE cycle T; ends in T+4 (or T+5 if res_ready).
  task automatic run_one(input logic id, input logic [7:0] a, input logic [7:0] b,
                         input logic elt, input logic eeq, input logic egt,
                         input string tag);
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b;
    end
    #1;
    chk({tag, "_rdy"}, id ? req1_ready : req0_ready, 1'b1);
    chk({tag, "_rdy_other"}, id ? req0_ready : req1_ready, 1'b0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = ~a; req0_b = ~b; req1_a = ~a; req1_b = ~b;
    chk({tag, "_busy"}, busy, 1'b1);
    tick();
    tick();
    chk({tag, "_early_vld"}, res_valid, 1'b0);
    tick();
    chk({tag, "_vld"}, res_valid, 1'b1);
    chk({tag, "_id"}, res_id, id);
    chk({tag, "_lt"}, res_lt, elt);
    chk({tag, "_eq"}, res_eq, eeq);
    chk({tag, "_gt"}, res_gt, egt);
    if (res_ready) begin
      tick();
      chk({tag, "_idle"}, busy, 1'b0);
    end
  endtask

  initial begin
    logic exp_id;
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    req0_valid = 1'b1; req0_a = 8'h00; req0_b = 8'h00;
    req1_valid = 1'b0; req1_a = 8'h00; req1_b = 8'h00;
    res_ready = 1'b1;

    repeat (2) tick();
    chk("rst_rdy0", req0_ready, 1'b0);
    chk("rst_vld", res_valid, 1'b0);
    chk("rst_id", res_id, 1'b0);
    chk("rst_lt", res_lt, 1'b0);
    chk("rst_eq", res_eq, 1'b1);
    chk("rst_gt", res_gt, 1'b0);
    chk("rst_busy", busy, 1'b0);
    req0_valid = 1'b0;
    rst = 1'b0;
    tick();

    run_one(1'b0, 8'h5A, 8'h5A, 1'b0, 1'b1, 1'b0, "eq5a");
    run_one(1'b1, 8'h01, 8'h02, 1'b1, 1'b0, 1'b0, "lsb_lt");
    run_one(1'b0, 8'h80, 8'h7F, SGN, 1'b0, ~SGN, "msb80");
    run_one(1'b1, 8'hC3, 8'h3C, SGN, 1'b0, ~SGN, "c3_3c");

    // Both requesters valid continuously: accepts every 5 cycles, 0,1,0,1.
    req0_valid = 1'b1; req0_a = 8'h10; req0_b = 8'h20;
    req1_valid = 1'b1; req1_a = 8'h33; req1_b = 8'h22;
    for (int c = 0; c < 20; c++) begin
      #1;
      exp_id = ((c / 5) % 2) == 1;
      chk("rr_rdy0", req0_ready, (c % 5 == 0) && !exp_id);
      chk("rr_rdy1", req1_ready, (c % 5 == 0) && exp_id);
      chk("rr_vld", res_valid, c % 5 == 4);
      if (c % 5 == 4) begin
        chk("rr_id", res_id, exp_id);
        chk("rr_lt", res_lt, !exp_id);
        chk("rr_gt", res_gt, exp_id);
      end
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Consumer stalls for 6 cycles: result held, no new acceptance.
    res_ready = 1'b0;
    run_one(1'b0, 8'h77, 8'h70, 1'b0, 1'b0, 1'b1, "stall");
    req0_valid = 1'b1; req0_a = 8'h01; req0_b = 8'h02;
    req1_valid = 1'b1; req1_a = 8'h44; req1_b = 8'h45;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("hold_vld", res_valid, 1'b1);
      chk("hold_gt", res_gt, 1'b1);
      chk("hold_lt", res_lt, 1'b0);
      chk("hold_id", res_id, 1'b0);
      chk("hold_rdy0", req0_ready, 1'b0);
      chk("hold_rdy1", req1_ready, 1'b0);
      chk("hold_busy", busy, 1'b1);
      tick();
    end
    res_ready = 1'b1;
    #1;
    chk("rel_vld", res_valid, 1'b1);
    chk("rel_rdy1", req1_ready, 1'b0);
    tick();
    #1;
    chk("post_busy", busy, 1'b0);
    chk("post_vld", res_valid, 1'b0);
    chk("post_rdy1", req1_ready, 1'b1);
    chk("post_rdy0", req0_ready, 1'b0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    tick();
    chk("post_early_vld", res_valid, 1'b0);
    tick();
    chk("post_res_vld", res_valid, 1'b1);
    chk("post_res_id", res_id, 1'b1);
    chk("post_res_lt", res_lt, 1'b1);
    chk("post_res_eq", res_eq, 1'b0);
    tick();

    // Reset in the second RUN cycle aborts the compare.
    req0_valid = 1'b1; req0_a = 8'h01; req0_b = 8'h00;
    #1;
    chk("abort_rdy", req0_ready, 1'b1);
    tick();
    req0_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("abort_vld", res_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_eq", res_eq, 1'b1);
    chk("abort_gt", res_gt, 1'b0);
    rst = 1'b0;
    tick();
    chk("abort_quiet_vld", res_valid, 1'b0);
    chk("abort_quiet_busy", busy, 1'b0);
    run_one(1'b0, 8'h9C, 8'h9B, 1'b0, 1'b0, 1'b1, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
